// File: rtl/bus_pkg.sv
// bus_pkg: shared transfer, response and master-state types for the system bus
package bus_pkg;
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_t;
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} mstate_t;
endpackage

// File: rtl/bus_master_if_if.sv
// bus_master_if_if: system-bus signal bundle between an initiator and the bus fabric
interface bus_master_if_if import bus_pkg::*; #(parameter int DWidth = 32);
  trans_t              m2s_trans_o;
  logic                m2s_write_o;
  logic [DWidth-1:0]   m2s_addr_o;
  logic [DWidth-1:0]   m2s_wdata_o;
  logic                b2m_ready_i;
  logic                b2m_resp_i;
  logic [DWidth-1:0]   b2m_rdata_i;
  modport master (
    output m2s_trans_o, m2s_write_o, m2s_addr_o, m2s_wdata_o,
    input  b2m_ready_i, b2m_resp_i, b2m_rdata_i
  );
  modport slave (
    input  m2s_trans_o, m2s_write_o, m2s_addr_o, m2s_wdata_o,
    output b2m_ready_i, b2m_resp_i, b2m_rdata_i
  );
endinterface

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: per-phase wait-state counter that flags when the limit is reached
module bus_wait_timer #(parameter int Limit = 256) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int W = $clog2(Limit + 1);
  logic [W-1:0] r_cnt;
  // count wait cycles, restarting at every phase change and saturating at the limit
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_cnt <= '0;
    else if (clr_i) r_cnt <= '0;
    else if (inc_i && !expired_o) r_cnt <= r_cnt + W'(1);
  assign expired_o = r_cnt == W'(Limit);
endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: core req/ready to two-phase bus adapter; BUS_TIMEOUT_EN adds a wait-state timeout
module bus_master_if import bus_pkg::*; #(
  parameter int DWidth = 32
`ifdef BUS_TIMEOUT_EN
  , parameter int TimeoutCycles = 256
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              err_o,
  bus_master_if_if.master   bus
);
  mstate_t           r_state, w_next;
  logic              r_write, r_err;
  logic [DWidth-1:0] r_addr, r_wdata, r_rdata;
  logic              w_phase, w_expired, w_misalign, w_bus_done;
  assign w_phase    = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_misalign = addr_i[1:0] != 2'b00;
  assign w_bus_done = (r_state == S_DATA) && !w_expired;
`ifdef BUS_TIMEOUT_EN
  bus_wait_timer #(.Limit(TimeoutCycles)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_next != r_state),
    .inc_i     (w_phase && !bus.b2m_ready_i),
    .expired_o (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: misaligned requests skip the bus, a timeout abandons the current phase
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !req_i ? S_IDLE : w_misalign ? S_RESP : S_ADDR;
      S_ADDR:  w_next = w_expired ? S_RESP : bus.b2m_ready_i ? S_DATA : S_ADDR;
      S_DATA:  w_next = (w_expired || bus.b2m_ready_i) ? S_RESP : S_DATA;
      default: w_next = S_IDLE;
    endcase
  end
  // request latches in idle; completion data/error captured on entry to the response state
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req_i) begin
        r_write <= write_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
      if (w_next == S_RESP) begin
        r_rdata <= (w_bus_done && !r_write) ? bus.b2m_rdata_i : '0;
        r_err   <= w_bus_done ? bus.b2m_resp_i : RESP_ERROR;
      end
    end
  assign ready_o         = r_state == S_RESP;
  assign rdata_o         = r_rdata;
  assign err_o           = r_err;
  assign bus.m2s_trans_o = (r_state == S_ADDR && !w_expired) ? TRANS_NONSEQ : TRANS_IDLE;
  assign bus.m2s_write_o = w_phase && r_write;
  assign bus.m2s_addr_o  = w_phase ? r_addr : '0;
  assign bus.m2s_wdata_o = (r_state == S_DATA && r_write) ? r_wdata : '0;
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed self-checking bench for bus_master_if; BUS_TIMEOUT_EN adds the timeout case
module tb_bus_master_if;
  import bus_pkg::*;
  logic        clk, rst, req, wr, ready, err;
  logic [31:0] addr, wdata, rdata;
  int          n_cmp, n_err;
  int          x_lat, x_ns, x_first, x_dcyc, x_wd_ok;
  logic [31:0] x_addr, x_rdata;
  logic        x_write, x_err;
  bus_master_if_if #(.DWidth(32)) bus ();
  bus_master_if #(
    .DWidth(32)
`ifdef BUS_TIMEOUT_EN
    , .TimeoutCycles(8)
`endif
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .write_i (wr),
    .addr_i  (addr),
    .wdata_i (wdata),
    .ready_o (ready),
    .rdata_o (rdata),
    .err_o   (err),
    .bus     (bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd, input int dw,
                      input logic rsp, input logic [31:0] rd, input logic keep);
    logic in_data, seen;
    int dc;
    req = 1; wr = w; addr = a; wdata = wd;
    in_data = 0; dc = 0;
    x_lat = -1; x_ns = 0; x_first = -1; x_wd_ok = 1;
    for (int c = 0; c < 40 && x_lat < 0; c++) begin
      if (in_data) begin
        bus.b2m_ready_i = dc >= dw;
        bus.b2m_resp_i  = rsp;
        bus.b2m_rdata_i = (dc >= dw) ? rd : 32'h0BAD_0BAD;
        if (bus.m2s_wdata_o !== (w ? wd : 32'h0)) x_wd_ok = 0;
        dc++;
      end else begin
        bus.b2m_ready_i = 1; bus.b2m_resp_i = 0; bus.b2m_rdata_i = 32'h0;
      end
      seen = bus.m2s_trans_o == TRANS_NONSEQ;
      if (seen) begin
        x_ns++;
        if (x_first < 0) begin
          x_first = c; x_addr = bus.m2s_addr_o; x_write = bus.m2s_write_o;
        end
      end
      @(posedge clk);
      in_data = seen || (in_data && !bus.b2m_ready_i);
      #1;
      if (ready) begin
        x_lat = c + 1; x_rdata = rdata; x_err = err;
      end else @(negedge clk);
    end
    x_dcyc = dc;
    if (!keep) req = 0;
    bus.b2m_ready_i = 1; bus.b2m_resp_i = 0;
  endtask
  initial begin
    int cnt;
    n_cmp = 0; n_err = 0;
    rst = 1; req = 0; wr = 0; addr = 0; wdata = 0;
    bus.b2m_ready_i = 1; bus.b2m_resp_i = 0; bus.b2m_rdata_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_trans", bus.m2s_trans_o, TRANS_IDLE);
    chk("rst_addr", bus.m2s_addr_o, 0);
    rst = 0;
    @(negedge clk);
    xfer(0, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    chk("rd_lat", x_lat, 3);
    chk("rd_nonseq", x_ns, 1);
    chk("rd_addr", x_addr, 32'h0000_0100);
    chk("rd_write", x_write, 0);
    chk("rd_rdata", x_rdata, 32'hDEAD_BEEF);
    chk("rd_err", x_err, 0);
    repeat (2) @(negedge clk);
    chk("rd_pulse", ready, 0);
    chk("rd_hold", rdata, 32'hDEAD_BEEF);
    xfer(1, 32'h0000_0200, 32'h1234_5678, 2, 0, 32'hFFFF_0000, 0);
    chk("wr_lat", x_lat, 5);
    chk("wr_dcyc", x_dcyc, 3);
    chk("wr_wdata", x_wd_ok, 1);
    chk("wr_write", x_write, 1);
    chk("wr_rdata", x_rdata, 0);
    chk("wr_err", x_err, 0);
    repeat (2) @(negedge clk);
    xfer(0, 32'h0000_0180, 32'h0, 1, 1, 32'h0000_00AA, 0);
    chk("er_lat", x_lat, 4);
    chk("er_err", x_err, 1);
    repeat (2) @(negedge clk);
    xfer(0, 32'h0000_0102, 32'h0, 0, 0, 32'h5555_5555, 0);
    chk("mis_lat", x_lat, 1);
    chk("mis_nonseq", x_ns, 0);
    chk("mis_err", x_err, 1);
    chk("mis_rdata", x_rdata, 0);
    repeat (2) @(negedge clk);
    xfer(0, 32'h0000_0104, 32'h0, 0, 0, 32'h1111_1111, 1);
    chk("b2b1_lat", x_lat, 3);
    chk("b2b1_rdata", x_rdata, 32'h1111_1111);
    xfer(0, 32'h0000_0108, 32'h0, 0, 0, 32'h2222_2222, 0);
    chk("b2b2_gap", x_first, 2);
    chk("b2b2_lat", x_lat, 4);
    chk("b2b2_addr", x_addr, 32'h0000_0108);
    chk("b2b2_rdata", x_rdata, 32'h2222_2222);
    repeat (2) @(negedge clk);
    req = 1; wr = 0; addr = 32'h0000_0300; bus.b2m_ready_i = 1;
    @(negedge clk);
    chk("ab_trans", bus.m2s_trans_o, TRANS_NONSEQ);
    @(negedge clk);
    bus.b2m_ready_i = 0;
    chk("ab_addr_dp", bus.m2s_addr_o, 32'h0000_0300);
    rst = 1;
    #1;
    chk("ab_ready", ready, 0);
    chk("ab_rdata", rdata, 0);
    chk("ab_err", err, 0);
    chk("ab_trans0", bus.m2s_trans_o, TRANS_IDLE);
    chk("ab_addr", bus.m2s_addr_o, 0);
    req = 0;
    repeat (2) @(negedge clk);
    rst = 0; bus.b2m_ready_i = 1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    chk("ab_noready", cnt, 0);
    xfer(0, 32'h0000_010C, 32'h0, 0, 0, 32'h3333_3333, 0);
    chk("post_rdata", x_rdata, 32'h3333_3333);
    repeat (2) @(negedge clk);
`ifdef BUS_TIMEOUT_EN
    req = 1; wr = 0; addr = 32'h0000_0400;
    bus.b2m_ready_i = 0; bus.b2m_rdata_i = 32'h5A5A_5A5A;
    x_ns = 0; x_lat = -1;
    for (int c = 0; c < 30 && x_lat < 0; c++) begin
      if (bus.m2s_trans_o == TRANS_NONSEQ) x_ns++;
      @(posedge clk);
      #1;
      if (ready) begin
        x_lat = c + 1; x_rdata = rdata; x_err = err;
      end else @(negedge clk);
    end
    req = 0;
    chk("to_nonseq", x_ns, 8);
    chk("to_lat", x_lat, 10);
    chk("to_err", x_err, 1);
    chk("to_rdata", x_rdata, 0);
    @(negedge clk);
    bus.b2m_ready_i = 1; bus.b2m_resp_i = 0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    chk("to_late", cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
